// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module : fft_pkg
// Shared widths, complex sample type and round/saturate helper for FFT stages.
// Rev    : 1.0
// ============================================================================
package fft_pkg;

    localparam int DATA_WIDTH   = 16;
    localparam int DATA_WIDTH_I = 3;
    localparam int DATA_WIDTH_F = 12;
    // Wide enough for a full complex-product sum plus the rounding offset
    localparam int WIDE_W       = 2*DATA_WIDTH + 2;

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] re;
        logic signed [DATA_WIDTH-1:0] im;
    } cplx_t;

    // Returns {sat, result}: add half an output LSB, shift right, clamp to DATA_WIDTH.
    function automatic logic [DATA_WIDTH:0] sat_round(
        input logic signed [WIDE_W-1:0]         value,
        input logic        [5:0]                shift
    );
        logic signed [WIDE_W-1:0]          w_half;
        logic signed [WIDE_W-1:0]          w_shr;
        logic        [WIDE_W-DATA_WIDTH:0] w_top;
        logic                              w_sat;
        logic        [DATA_WIDTH-1:0]      w_res;
        w_half = (shift == 6'd0) ? '0 : (WIDE_W'(1) <<< (shift - 6'd1));
        w_shr  = (value + w_half) >>> shift;
        w_top  = w_shr[WIDE_W-1:DATA_WIDTH-1];
        w_sat  = !((&w_top) || !(|w_top));
        w_res  = w_sat ? {w_shr[WIDE_W-1], {(DATA_WIDTH-1){~w_shr[WIDE_W-1]}}}
                       : w_shr[DATA_WIDTH-1:0];
        return {w_sat, w_res};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_bfly2_if.sv
`default_nettype none
// ============================================================================
// Module : fft_bfly2_if
// Handshake and sample bus of one radix-2 butterfly stage.
// Rev    : 1.0
// ============================================================================
interface fft_bfly2_if;
    import fft_pkg::*;

    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] X_0_re;
    logic signed [DATA_WIDTH-1:0] X_0_im;
    logic signed [DATA_WIDTH-1:0] X_1_re;
    logic signed [DATA_WIDTH-1:0] X_1_im;
    logic signed [DATA_WIDTH-1:0] twiddle_re;
    logic signed [DATA_WIDTH-1:0] twiddle_im;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] Y_0_re;
    logic signed [DATA_WIDTH-1:0] Y_0_im;
    logic signed [DATA_WIDTH-1:0] Y_1_re;
    logic signed [DATA_WIDTH-1:0] Y_1_im;
    logic                         ovf;
    logic                         ovf_clear;

    modport master (
        output in_valid, X_0_re, X_0_im, X_1_re, X_1_im, twiddle_re, twiddle_im,
        output out_ready, ovf_clear,
        input  in_ready, out_valid, Y_0_re, Y_0_im, Y_1_re, Y_1_im, ovf
    );

    modport slave (
        input  in_valid, X_0_re, X_0_im, X_1_re, X_1_im, twiddle_re, twiddle_im,
        input  out_ready, ovf_clear,
        output in_ready, out_valid, Y_0_re, Y_0_im, Y_1_re, Y_1_im, ovf
    );

endinterface
`default_nettype wire

// File: rtl/cmul_rnd.sv
`default_nettype none
// ============================================================================
// Module : cmul_rnd
// Combinational complex multiply X1*W with round-half-up and saturation.
// Rev    : 1.0
// ============================================================================
module cmul_rnd
    import fft_pkg::*;
(
    input  cplx_t i_x,
    input  cplx_t i_w,
    output cplx_t o_p,
    output logic  o_sat
);

    localparam int c_PW = 2*DATA_WIDTH + 1;

    logic signed [c_PW-1:0] w_rr;
    logic signed [c_PW-1:0] w_ii;
    logic signed [c_PW-1:0] w_ri;
    logic signed [c_PW-1:0] w_ir;
    logic signed [c_PW-1:0] w_p_re;
    logic signed [c_PW-1:0] w_p_im;
    logic                   w_sat_re;
    logic                   w_sat_im;

    always_comb begin
        w_rr   = c_PW'($signed(i_x.re)) * c_PW'($signed(i_w.re));
        w_ii   = c_PW'($signed(i_x.im)) * c_PW'($signed(i_w.im));
        w_ri   = c_PW'($signed(i_x.re)) * c_PW'($signed(i_w.im));
        w_ir   = c_PW'($signed(i_x.im)) * c_PW'($signed(i_w.re));
        w_p_re = w_rr - w_ii;
        w_p_im = w_ri + w_ir;
        {w_sat_re, o_p.re} = sat_round(WIDE_W'(w_p_re), 6'(DATA_WIDTH_F));
        {w_sat_im, o_p.im} = sat_round(WIDE_W'(w_p_im), 6'(DATA_WIDTH_F));
        o_sat = w_sat_re | w_sat_im;
    end

endmodule
`default_nettype wire

// File: rtl/fft_bfly2.sv
`default_nettype none
// ============================================================================
// Module : fft_bfly2
// Two-stage pipelined radix-2 DIT butterfly with valid/ready flow control.
// Rev    : 1.0
// ============================================================================
module fft_bfly2
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int DATA_WIDTH_I = 3,
    parameter int DATA_WIDTH_F = 12,
    parameter int SCALE        = 0
)(
    input  logic       clk,
    input  logic       reset,
    fft_bfly2_if.slave bus
);

    // Sample type and rounding helper are sized by the package
    if (DATA_WIDTH != fft_pkg::DATA_WIDTH || DATA_WIDTH_F != fft_pkg::DATA_WIDTH_F ||
        DATA_WIDTH != 1 + DATA_WIDTH_I + DATA_WIDTH_F) begin : g_cfg_check
        $error("fft_bfly2: width parameters must match fft_pkg");
    end

    localparam int         c_SW       = DATA_WIDTH + 1;
    localparam logic [5:0] c_S2_SHIFT = (SCALE != 0) ? 6'd1 : 6'd0;

    cplx_t                  w_x0, w_x1, w_tw, w_p;
    cplx_t                  w_y0, w_y1;
    logic                   w_mul_sat, w_add_sat, w_ovf_set;
    logic                   w_en1, w_en2;
    logic signed [c_SW-1:0] w_s0_re, w_s0_im, w_s1_re, w_s1_im;
    logic                   w_sat0r, w_sat0i, w_sat1r, w_sat1i;

    cplx_t                  r_s1_x0, r_s1_p;
    logic                   r_s1_valid;
    cplx_t                  r_y0, r_y1;
    logic                   r_out_valid;
    logic                   r_ovf;

    assign w_x0 = {bus.X_0_re, bus.X_0_im};
    assign w_x1 = {bus.X_1_re, bus.X_1_im};
    assign w_tw = {bus.twiddle_re, bus.twiddle_im};

    assign w_en2        = !r_out_valid || bus.out_ready;
    assign w_en1        = !r_s1_valid || w_en2;
    assign bus.in_ready = w_en1;

    cmul_rnd u_cmul (
        .i_x   (w_x1),
        .i_w   (w_tw),
        .o_p   (w_p),
        .o_sat (w_mul_sat)
    );

    always_comb begin
        w_s0_re = c_SW'($signed(r_s1_x0.re)) + c_SW'($signed(r_s1_p.re));
        w_s0_im = c_SW'($signed(r_s1_x0.im)) + c_SW'($signed(r_s1_p.im));
        w_s1_re = c_SW'($signed(r_s1_x0.re)) - c_SW'($signed(r_s1_p.re));
        w_s1_im = c_SW'($signed(r_s1_x0.im)) - c_SW'($signed(r_s1_p.im));
        {w_sat0r, w_y0.re} = sat_round(WIDE_W'(w_s0_re), c_S2_SHIFT);
        {w_sat0i, w_y0.im} = sat_round(WIDE_W'(w_s0_im), c_S2_SHIFT);
        {w_sat1r, w_y1.re} = sat_round(WIDE_W'(w_s1_re), c_S2_SHIFT);
        {w_sat1i, w_y1.im} = sat_round(WIDE_W'(w_s1_im), c_S2_SHIFT);
        w_add_sat = w_sat0r | w_sat0i | w_sat1r | w_sat1i;
    end

    // Only saturation of a beat actually moving through a stage counts
    assign w_ovf_set = (w_en1 && bus.in_valid && w_mul_sat) ||
                       (w_en2 && r_s1_valid && w_add_sat);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_x0    <= '0;
            r_s1_p     <= '0;
        end else if (w_en1) begin
            r_s1_valid <= bus.in_valid;
            r_s1_x0    <= w_x0;
            r_s1_p     <= w_p;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_y0        <= '0;
            r_y1        <= '0;
        end else if (w_en2) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_y0 <= w_y0;
                r_y1 <= w_y1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (bus.ovf_clear) begin
            r_ovf <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.Y_0_re    = r_y0.re;
    assign bus.Y_0_im    = r_y0.im;
    assign bus.Y_1_re    = r_y1.re;
    assign bus.Y_1_im    = r_y1.im;
    assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire
